mc_control_fsm: RTL and testbench

//  Multicycle main controller for the RV32I-subset core (lw, sw, R-type, I-type ALU, beq, jal).

---
 rtl/mc_pkg.sv | 132 +++++++++++++
 rtl/mc_alu_decoder.sv | 29 ++
 rtl/mc_control_fsm.sv | 115 +++++++++++
 tb/tb_mc_control_fsm.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, mux-select codes,
// ALU codes, and the per-state control word.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // branch marks BEQ, where the PC enable comes from the live zero flag
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_BEQ: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decode: the state forces add/sub, otherwise funct3 (and funct7_5 for R-type) selects.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       isRtype,
    output logic [2:0] aluControl
);

    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  aluControl = (isRtype && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControl = ALU_SLT;
                    3'b110:  aluControl = ALU_OR;
                    3'b111:  aluControl = ALU_AND;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I-subset main controller (Moore FSM with registered control word).
// Define MC_ILLEGAL_TRAP_EN to trap unknown opcodes into a sticky HALT state.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               funct7_5,
    input  logic               zero,
    output logic               pcWrite,
    output logic               adrSrc,
    output logic               memWrite,
    output logic               irWrite,
    output logic               regWrite,
    output logic [1:0]         resultSrc,
    output logic [1:0]         aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [2:0]         immSrc,
    output logic [2:0]         aluControl,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   instret,
    output logic               illegal
);

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI,
            S_JAL:      state_d = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT:     state_d = S_HALT;
`endif
            default:    state_d = S_FETCH;
        endcase

        // Outputs are registered from the next state so they line up with state_q
        ctrl_d = state_ctrl(state_d);

        instret_d = instret_q;
        if (state_d == S_FETCH) begin
            instret_d = instret_q + CNT_W'(1);
        end

`ifdef MC_ILLEGAL_TRAP_EN
        illegal_d = illegal_q | (state_d == S_HALT);
`else
        illegal_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ctrl_q    <= state_ctrl(S_FETCH);
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Write enables are gated by rst so an abandoned instruction cannot commit anything
    assign pcWrite   = ~rst & (ctrl_q.pc_write | (ctrl_q.branch & zero));
    assign irWrite   = ~rst & ctrl_q.ir_write;
    assign regWrite  = ~rst & ctrl_q.reg_write;
    assign memWrite  = ~rst & ctrl_q.mem_write;
    assign adrSrc    = ctrl_q.adr_src;
    assign resultSrc = ctrl_q.result_src;
    assign aluSrcA   = ctrl_q.alu_src_a;
    assign aluSrcB   = ctrl_q.alu_src_b;
    assign immSrc    = imm_sel(opcode);
    assign state     = STATE_W'(state_q);
    assign instret   = instret_q;
    assign illegal   = illegal_q;

    mc_alu_decoder u_alu_decoder (
        .aluOp      (ctrl_q.alu_op),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .isRtype    (state_q == S_EXECR),
        .aluControl (aluControl)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-instruction expected cycle traces are queued
// by the stimulus process and compared by a negedge monitor.
module tb_mc_control_fsm;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    typedef struct packed {
        logic [3:0]  st;
        logic        pcw;
        logic        adr;
        logic        memw;
        logic        irw;
        logic        regw;
        logic [1:0]  rs;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [2:0]  imm;
        logic [2:0]  alu;
        logic [31:0] cnt;
        logic        ill;
    } obs_t;

    typedef struct {
        obs_t  o;
        string nm;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        zero;
    logic        pcWrite, adrSrc, memWrite, irWrite, regWrite;
    logic [1:0]  resultSrc, aluSrcA, aluSrcB;
    logic [2:0]  immSrc, aluControl;
    logic [3:0]  state;
    logic [31:0] instret;
    logic        illegal;

    exp_t        sb_q[$];
    int          n_compared = 0;
    int          n_mismatched = 0;
    logic [31:0] exp_cnt = 0;
    logic        exp_ill = 1'b0;

    mc_control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .zero       (zero),
        .pcWrite    (pcWrite),
        .adrSrc     (adrSrc),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .regWrite   (regWrite),
        .resultSrc  (resultSrc),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .immSrc     (immSrc),
        .aluControl (aluControl),
        .state      (state),
        .instret    (instret),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_valid(input logic [6:0] op);
        return (op == LW) || (op == SW) || (op == RT) || (op == IT) || (op == BEQ) || (op == JAL);
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        if (op == SW)  return 3'b001;
        if (op == BEQ) return 3'b010;
        if (op == JAL) return 3'b011;
        return 3'b000;
    endfunction

    function automatic logic [2:0] exp_alu(input logic [2:0] f3, input logic f7, input bit is_r);
        if (f3 == 3'b000) return (is_r && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    // One expected cycle: the explicit controls plus opcode-driven imm, counter and sticky flag
    function automatic obs_t step(input logic [3:0] st, input logic pcw, input logic adr,
                                  input logic memw, input logic irw, input logic regw,
                                  input logic [1:0] rs, input logic [1:0] sa,
                                  input logic [1:0] sb, input logic [2:0] alu);
        obs_t o;
        o.st = st; o.pcw = pcw; o.adr = adr; o.memw = memw; o.irw = irw; o.regw = regw;
        o.rs = rs; o.sa = sa; o.sb = sb; o.alu = alu;
        o.imm = exp_imm(opcode);
        o.cnt = exp_cnt;
        o.ill = exp_ill;
        return o;
    endfunction

    task automatic push(input string nm, input obs_t o);
        exp_t e;
        e.o  = o;
        e.nm = nm;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e, input obs_t act);
        n_compared++;
        if (act !== e.o) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got state=%0d word=%h, want state=%0d word=%h",
                     e.nm, act.st, act, e.o.st, e.o);
        end
    endtask

    // Queues one instruction's cycle trace, then lets the DUT run it back to FETCH
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic z, input string nm);
        int lat;
        opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
        push({nm, ".fetch"},  step(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000));
        push({nm, ".decode"}, step(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000));
        lat = 2;
        if (op == LW || op == SW) begin
            push({nm, ".memadr"}, step(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000));
            if (op == LW) begin
                push({nm, ".memread"}, step(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000));
                push({nm, ".memwb"},   step(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000));
                lat = 5;
            end else begin
                push({nm, ".memwrite"}, step(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000));
                lat = 4;
            end
        end else if (op == RT || op == IT || op == JAL) begin
            if (op == RT)
                push({nm, ".execr"}, step(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, exp_alu(f3, f7, 1'b1)));
            else if (op == IT)
                push({nm, ".execi"}, step(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, exp_alu(f3, f7, 1'b0)));
            else
                push({nm, ".jal"},   step(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000));
            push({nm, ".aluwb"}, step(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000));
            lat = 4;
        end else if (op == BEQ) begin
            push({nm, ".beq"}, step(4'd9, z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001));
            lat = 3;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
            exp_ill = 1'b1;
            for (int i = 0; i < 10; i++)
                push({nm, ".halt"}, step(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000));
            lat = 12;
`else
            lat = 2;
`endif
        end
        repeat (lat) @(posedge clk);
        #1;
`ifdef MC_ILLEGAL_TRAP_EN
        if (is_valid(op)) exp_cnt = exp_cnt + 1;
`else
        exp_cnt = exp_cnt + 1;
`endif
    endtask

    // One cycle of rst: the current state is still shown, but with every write enable off
    task automatic resetPulse(input obs_t cur, input string nm);
        cur.pcw = 1'b0; cur.irw = 1'b0; cur.regw = 1'b0; cur.memw = 1'b0;
        push(nm, cur);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 0;
        exp_ill = 1'b0;
    endtask

    initial begin : monitor
        obs_t act;
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act.st = state; act.pcw = pcWrite; act.adr = adrSrc; act.memw = memWrite;
                act.irw = irWrite; act.regw = regWrite; act.rs = resultSrc; act.sa = aluSrcA;
                act.sb = aluSrcB; act.imm = immSrc; act.alu = aluControl; act.cnt = instret;
                act.ill = illegal;
                checkOutput(e, act);
            end
        end
    end

    initial begin : watchdog
        #200000;
        n_mismatched++;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin : stimulus
        logic [6:0] ops [6];
        logic [6:0] op;
        ops = '{LW, SW, RT, IT, BEQ, JAL};
        rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0;
        push("reset0", step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000));
        push("reset1", step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(LW,  3'b010, 1'b0, 1'b0, "lw");
        applyStimulus(SW,  3'b010, 1'b0, 1'b1, "sw");
        applyStimulus(RT,  3'b000, 1'b1, 1'b0, "r_sub");
        applyStimulus(IT,  3'b000, 1'b1, 1'b0, "i_add_f7");
        applyStimulus(RT,  3'b111, 1'b0, 1'b0, "r_and");
        applyStimulus(IT,  3'b010, 1'b0, 1'b0, "i_slt");
        applyStimulus(RT,  3'b110, 1'b1, 1'b0, "r_or");
        applyStimulus(BEQ, 3'b000, 1'b0, 1'b1, "beq_taken");
        applyStimulus(BEQ, 3'b000, 1'b0, 1'b0, "beq_not_taken");
        applyStimulus(JAL, 3'b101, 1'b1, 1'b0, "jal");

        opcode = LW; funct3 = 3'b010; funct7_5 = 1'b0; zero = 1'b0;
        push("lw_rst.fetch",  step(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000));
        push("lw_rst.decode", step(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000));
        push("lw_rst.memadr", step(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000));
        repeat (3) @(posedge clk);
        #1;
        resetPulse(step(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000), "lw_rst.memread");
        applyStimulus(SW, 3'b000, 1'b0, 1'b0, "sw_after_rst");

        for (int n = 0; n < 60; n++) begin
`ifdef MC_ILLEGAL_TRAP_EN
            op = ops[$urandom_range(0, 5)];
`else
            if ($urandom_range(0, 6) == 6) begin
                do op = 7'($urandom_range(0, 127)); while (is_valid(op));
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
`endif
            applyStimulus(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0, "illegal");
`ifdef MC_ILLEGAL_TRAP_EN
        resetPulse(step(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000), "halt_rst");
`endif
        applyStimulus(LW, 3'b010, 1'b0, 1'b0, "lw_final");

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
